// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC, combinational imem read port, small fetch FIFO toward decode.
// Optional `IFU_STATIC_PREDICT_EN: backward B-type branches are predicted taken at push time.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 64,
    parameter int unsigned BUF_DEPTH  = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_en,
    output logic [31:0]      read_addr,
    input  logic [31:0]      instruction,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [31:0]      if_instr,
    output logic [31:0]      if_pc,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             halt_req,
    output logic             halted,
    output logic             fetch_fault,
    output logic [CNT_W-1:0] fetch_count,
`ifdef IFU_STATIC_PREDICT_EN
    output logic             if_pred_taken,
`endif
    output logic [1:0]       o_dbg_state
);

    localparam int          PTR_W      = $clog2(BUF_DEPTH);
    localparam int          CW         = PTR_W + 1;
    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]       r_state;
    logic [31:0]      r_pc;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CNT_W-1:0] r_fetch_count;
    logic [31:0]      r_mem_pc    [BUF_DEPTH];
    logic [31:0]      r_mem_instr [BUF_DEPTH];

    logic [1:0]  w_state_n;
    logic [1:0]  w_mode_n;
    logic        w_valid;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_pc_bad;
    logic        w_redir_bad;
    logic [31:0] w_next_pc;
    logic        w_pred;

    assign w_valid     = (r_count != '0);
    assign w_full      = (r_count == CW'(BUF_DEPTH));
    assign w_pc_bad    = (r_pc[1:0] != 2'b00) || (r_pc >= IMEM_LIMIT);
    assign w_redir_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= IMEM_LIMIT);

    // A flush dominates a same-cycle pop, so the pop is suppressed during redirect.
    assign w_pop  = w_valid && if_ready && !redirect_valid;
    assign w_push = (r_state == S_RUN) && !redirect_valid && !w_pc_bad && (!w_full || w_pop);

`ifdef IFU_STATIC_PREDICT_EN
    logic [31:0] w_b_imm;
    logic        r_mem_pred [BUF_DEPTH];
    assign w_b_imm   = {{19{instruction[31]}}, instruction[31], instruction[7],
                        instruction[30:25], instruction[11:8], 1'b0};
    assign w_pred    = (instruction[6:0] == 7'b1100011) && instruction[31];
    assign w_next_pc = w_pred ? (r_pc + w_b_imm) : (r_pc + 32'd4);
    assign if_pred_taken = w_valid && r_mem_pred[r_rd_ptr];
`else
    assign w_pred    = 1'b0;
    assign w_next_pc = r_pc + 32'd4;
`endif

    // Halt dominates fetch_en identically from IDLE, RUN and HALT.
    assign w_mode_n = halt_req ? S_HALT : (fetch_en ? S_RUN : S_IDLE);

    always_comb begin
        w_state_n = r_state;
        if (redirect_valid) begin
            if (r_state == S_FAULT) begin
                if (!w_redir_bad) w_state_n = fetch_en ? S_RUN : S_IDLE;
            end else begin
                w_state_n = w_mode_n;
            end
        end else if (w_pc_bad || (r_state == S_FAULT)) begin
            w_state_n = S_FAULT;
        end else begin
            w_state_n = w_mode_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_state_n;
            if (redirect_valid) begin
                r_pc     <= redirect_pc;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_pc          <= w_next_pc;
                    r_wr_ptr      <= r_wr_ptr + PTR_W'(1);
                    r_fetch_count <= r_fetch_count + CNT_W'(1);
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage is not reset; outputs are masked by the occupancy count instead.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_pc;
            r_mem_instr[r_wr_ptr] <= instruction;
`ifdef IFU_STATIC_PREDICT_EN
            r_mem_pred[r_wr_ptr]  <= w_pred;
`endif
        end
    end

    assign read_addr   = r_pc;
    assign if_valid    = w_valid;
    assign if_pc       = w_valid ? r_mem_pc[r_rd_ptr] : 32'd0;
    assign if_instr    = w_valid ? r_mem_instr[r_rd_ptr] : 32'd0;
    assign halted      = (r_state == S_HALT) && !w_valid;
    assign fetch_fault = (r_state == S_FAULT);
    assign fetch_count = r_fetch_count;
    assign o_dbg_state = r_state;

    logic w_unused;
    assign w_unused = w_pred;

endmodule
